seq_divider: RTL

- Iterative restoring divider that consumes START_DIV from the calculator control unit, with operands A and B from the operand registers loaded under LdA/LdB.
- Produces quotient and remainder after a fixed WIDTH-iteration sequence; flags divide-by-zero.
- Clocked by the fast board clock CLK. START_DIV comes from the slow-ladder domain, so it is synchronized internally.
- START_DIV is a level that stays high while the control unit is in its DIV state. The divider acts only on its rising edge.

---
 rtl/calc_pkg.sv | 18 +
 rtl/sync_rise.sv | 30 +++
 rtl/seq_divider.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: divider FSM states, default datapath width
// and the one-hot operation codes used by the control unit.
package calc_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ITER = 2'b01,
    ST_DONE = 2'b10
  } div_state_t;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b1000;

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer for a slow-domain level followed by a rising-edge
// detector; o_pulse is one i_clk cycle wide.
module sync_rise (
  input  logic i_clk,
  input  logic i_clr_n,
  input  logic i_async,
  output logic o_pulse
);

  logic r_s1;
  logic r_s2;
  logic r_s2_d;

  // Synchronizer chain plus edge-detect history; cleared history makes a
  // level already high at reset release count as a fresh edge.
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s2_d <= 1'b0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
    end
  end

  assign o_pulse = r_s2 & ~r_s2_d;

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per CLK, MSB first.
// Start is a slow-domain level; only its synchronized rising edge is acted on.
module seq_divider
  import calc_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV0
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  div_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_dvd, w_dvd_nxt;
  logic [WIDTH-1:0] r_dvs, w_dvs_nxt;
  logic [WIDTH-1:0] r_rem, w_rem_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic [WIDTH-1:0] r_r, w_r_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_div0, w_div0_nxt;

  logic             w_start_pulse;
  logic [WIDTH:0]   w_acc;
  logic [WIDTH+1:0] w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_step;
  logic [WIDTH-1:0] w_dvd_step;

  sync_rise u_sync_rise (
    .i_clk   (CLK),
    .i_clr_n (CLR),
    .i_async (START),
    .o_pulse (w_start_pulse)
  );

  // Extra top bit on the trial subtraction acts as the borrow/sign flag.
  assign w_acc      = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial    = {1'b0, w_acc} - {2'b00, r_dvs};
  assign w_qbit     = ~w_trial[WIDTH+1];
  assign w_rem_step = w_qbit ? w_trial[WIDTH-1:0] : w_acc[WIDTH-1:0];
  assign w_dvd_step = {r_dvd[WIDTH-2:0], w_qbit};

  // Next-state and datapath update; Q/R only change on the last step.
  always_comb begin
    w_state_nxt = r_state;
    w_dvd_nxt   = r_dvd;
    w_dvs_nxt   = r_dvs;
    w_rem_nxt   = r_rem;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_r_nxt     = r_r;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_div0_nxt  = r_div0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_pulse) begin
          w_dvd_nxt = A;
          w_dvs_nxt = B;
          w_rem_nxt = {WIDTH{1'b0}};
          w_cnt_nxt = {CW{1'b0}};
          if (B == {WIDTH{1'b0}}) begin
            w_state_nxt = ST_DONE;
            w_q_nxt     = {WIDTH{1'b1}};
            w_r_nxt     = A;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_div0_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_ITER;
            w_busy_nxt  = 1'b1;
            w_done_nxt  = 1'b0;
            w_div0_nxt  = 1'b0;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_ITER: begin
        w_dvd_nxt = w_dvd_step;
        w_rem_nxt = w_rem_step;
        w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        if (r_cnt == LAST) begin
          w_state_nxt = ST_DONE;
          w_q_nxt     = w_dvd_step;
          w_r_nxt     = w_rem_step;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_ITER;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= ST_IDLE;
      r_dvd   <= {WIDTH{1'b0}};
      r_dvs   <= {WIDTH{1'b0}};
      r_rem   <= {WIDTH{1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_q     <= {WIDTH{1'b0}};
      r_r     <= {WIDTH{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dvd   <= w_dvd_nxt;
      r_dvs   <= w_dvs_nxt;
      r_rem   <= w_rem_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_r     <= w_r_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_div0  <= w_div0_nxt;
    end
  end

  assign Q    = r_q;
  assign R    = r_r;
  assign BUSY = r_busy;
  assign DONE = r_done;
  assign DIV0 = r_div0;

endmodule
